// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and prescale helper for the
// multi-channel countdown timer.
package timer_pkg;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_EXP  = 3;

  function automatic int calc_prescale(input int clock_frequency, input int ticks_per_second);
    return clock_frequency / ticks_per_second;
  endfunction

endpackage

// File: rtl/timer_multi_if.sv
// Peripheral-bus port bundle of the timer: register access plus interrupt.
interface timer_multi_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 16
);
  // No handshake: a write is accepted on the clk edge where en & wr_en = 1;
  // data_out is a zero-latency combinational read of addr while en = 1, 0 otherwise.
  logic                  en;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      data_out;
  logic                  irq;

  modport master (output en, wr_en, addr, data_in, input data_out, irq);
  modport slave  (input en, wr_en, addr, data_in, output data_out, irq);
endinterface

// File: rtl/timer_channel.sv
// One countdown channel: COUNT/RELOAD/CTRL state, tick handling and the
// sticky expiry flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_wr_count,
  input  logic             i_wr_reload,
  input  logic             i_wr_ctrl,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_reload,
  output logic [3:0]       o_ctrl,
  output logic             o_exp,
  output logic             o_ie
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_en;
  logic             r_auto;
  logic             r_ie;
  logic             r_exp;
  logic             w_apply;
  logic             w_expire;

  // A COUNT write in the tick cycle swallows that tick for this channel.
  assign w_apply  = i_tick & r_en & ~i_wr_count;
  assign w_expire = w_apply & (r_count == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_reload <= '0;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_ie     <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      if (i_wr_count) begin
        r_count <= i_data;
      end else if (w_apply) begin
        if (r_count == WIDTH'(1)) begin
          r_count <= (r_auto && (r_reload != '0)) ? r_reload : '0;
        end else if (r_count != '0) begin
          r_count <= r_count - WIDTH'(1);
        end
      end
      if (i_wr_reload) begin
        r_reload <= i_data;
      end
      if (i_wr_ctrl) begin
        r_en   <= i_data[CTRL_EN];
        r_auto <= i_data[CTRL_AUTO];
        r_ie   <= i_data[CTRL_IE];
      end
      // Expiry set takes priority over a simultaneous W1C.
      r_exp <= w_expire | (r_exp & ~(i_wr_ctrl & i_data[CTRL_EXP]));
    end
  end

  assign o_count  = r_count;
  assign o_reload = r_reload;
  assign o_ctrl   = {r_exp, r_ie, r_auto, r_en};
  assign o_exp    = r_exp;
  assign o_ie     = r_ie;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel memory-mapped countdown timer: shared prescaler, address
// decode, combinational read mux and registered level interrupt.
module timer_multi
  import timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY  = 50_000_000,
  parameter int TICKS_PER_SECOND = 1000,
  parameter int NUM_CHANNELS     = 4,
  parameter int WIDTH            = 16,
  parameter int ADDR_WIDTH       = 4
) (
  input logic           clk,
  input logic           rst_n,
  timer_multi_if.slave  bus
);

  localparam int PRESCALE = calc_prescale(CLOCK_FREQUENCY, TICKS_PER_SECOND);
  localparam int PW       = $clog2(PRESCALE);
  localparam int CW       = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;

  logic [PW-1:0]     r_presc;
  logic              r_irq;
  logic              w_tick;
  logic [CW-1:0]     w_chan;
  logic [1:0]        w_reg;
  logic              w_chan_ok;
  logic              w_wr;
  logic [WIDTH-1:0]  w_rdata;
  logic [WIDTH-1:0]  w_status;
  logic [WIDTH-1:0]  w_count  [NUM_CHANNELS];
  logic [WIDTH-1:0]  w_reload [NUM_CHANNELS];
  logic [3:0]        w_ctrl   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_exp;
  logic [NUM_CHANNELS-1:0] w_ie;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  // Free-running; bus traffic never touches it so tick phase is continuous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  generate
    if (ADDR_WIDTH > 2) begin : g_chan_addr
      assign w_chan = bus.addr[ADDR_WIDTH-1:2];
    end else begin : g_chan_zero
      assign w_chan = '0;
    end
  endgenerate

  assign w_reg     = bus.addr[1:0];
  assign w_chan_ok = (int'(w_chan) < NUM_CHANNELS);
  assign w_wr      = bus.en & bus.wr_en & w_chan_ok;

  generate
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      localparam logic [CW-1:0] CH = CW'(g);
      logic w_sel;
      assign w_sel = w_wr & (w_chan == CH);

      timer_channel #(.WIDTH(WIDTH)) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tick      (w_tick),
        .i_wr_count  (w_sel & (w_reg == REG_COUNT)),
        .i_wr_reload (w_sel & (w_reg == REG_RELOAD)),
        .i_wr_ctrl   (w_sel & (w_reg == REG_CTRL)),
        .i_data      (bus.data_in),
        .o_count     (w_count[g]),
        .o_reload    (w_reload[g]),
        .o_ctrl      (w_ctrl[g]),
        .o_exp       (w_exp[g]),
        .o_ie        (w_ie[g])
      );
    end
  endgenerate

  always_comb begin
    w_status = '0;
    w_status[NUM_CHANNELS-1:0] = w_exp;
    w_rdata = '0;
    if (bus.en && w_chan_ok) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (int'(w_chan) == i) begin
          case (w_reg)
            REG_COUNT:  w_rdata = w_count[i];
            REG_RELOAD: w_rdata = w_reload[i];
            REG_CTRL:   w_rdata = WIDTH'(w_ctrl[i]);
            default:    w_rdata = w_status;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_exp & w_ie);
    end
  end

  assign bus.data_out = w_rdata;
  assign bus.irq      = r_irq;

endmodule
